// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 boot loader: FSM state codes and default image geometry.
package jtdsp16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WR   = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int DEF_LEN  = 512;
  localparam int DEF_BASE = 0;

endpackage

// File: rtl/jtdsp16_prog_loader.sv
// Boot sequencer: copies LEN words from the ROM port into jtdsp16 program RAM
// and keeps the DSP in reset until the copy and the HOLD guard time are over.
//
// state | meaning
// IDLE  | after reset; waits for AUTO or start, dsp_rst high
// REQ   | rom_cs high, waiting for rom_ok on word idx
// WR    | prog_we high for one cen cycle, then next word or HOLD
// HOLD  | guard time after the last write, dsp_rst still high
// DONE  | image loaded, DSP released, start reloads
module jtdsp16_prog_loader
  import jtdsp16_pkg::*;
#(
  parameter int AW   = 12,
  parameter int DW   = 16,
  parameter int RW   = 22,
  parameter int LEN  = DEF_LEN,
  parameter int BASE = DEF_BASE,
  parameter int HOLD = 4,
  parameter int AUTO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  output logic          rom_cs,
  output logic [RW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output logic [AW-1:0] prog_addr,
  output logic [DW-1:0] prog_data,
  output logic          prog_we,
  output logic          dsp_rst,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] csum
);

  // One spare index bit lets LEN=2**AW reach its last word without wrapping.
  localparam int IW  = AW + 1;
  localparam int HCW = (HOLD < 2) ? 1 : $clog2(HOLD);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'((HOLD == 0) ? 0 : HOLD - 1);
  localparam logic [IW-1:0]  LAST     = IW'(LEN - 1);
  localparam logic [RW-1:0]  BASE_RW  = RW'(BASE);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic [HCW-1:0]  hold_cnt;

  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      hold_cnt  <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      csum      <= '0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if ((AUTO != 0) || start) begin
            state    <= ST_REQ;
            idx      <= '0;
            csum     <= '0;
            rom_cs   <= 1'b1;
            rom_addr <= BASE_RW;
            busy     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (rom_ok) begin
            prog_data <= rom_data;
            prog_addr <= idx[AW-1:0];
            csum      <= csum + rom_data;
            rom_cs    <= 1'b0;
            prog_we   <= 1'b1;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          prog_we <= 1'b0;
          if (idx == LAST) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            idx      <= idx_nxt;
            rom_addr <= BASE_RW + RW'(idx_nxt);
            rom_cs   <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state   <= ST_DONE;
            dsp_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state    <= ST_REQ;
            idx      <= '0;
            csum     <= '0;
            done     <= 1'b0;
            dsp_rst  <= 1'b1;
            busy     <= 1'b1;
            rom_cs   <= 1'b1;
            rom_addr <= BASE_RW;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// Bench for jtdsp16_prog_loader: three instances (auto 512 words, start-driven 4 words at 0x1000,
// full 4096-word image) driven by a latency-programmable ROM responder and a write-order model.
module tb_jtdsp16_prog_loader;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, cen, start;
  bit   [2:0] clr;
  wire  [2:0] cs, ok, we, drst, busy, done;
  wire  [RW-1:0] raddr [3];
  wire  [DW-1:0] rdata [3];
  wire  [DW-1:0] pdata [3];
  wire  [DW-1:0] csum  [3];
  wire  [AW-1:0] paddr [3];

  jtdsp16_prog_loader #(.AW(AW), .DW(DW), .RW(RW), .LEN(512), .BASE(0), .HOLD(4), .AUTO(1)) u0 (
    .clk(clk), .rst(rst[0]), .cen(cen[0]), .start(start[0]), .rom_cs(cs[0]), .rom_addr(raddr[0]),
    .rom_data(rdata[0]), .rom_ok(ok[0]), .prog_addr(paddr[0]), .prog_data(pdata[0]), .prog_we(we[0]),
    .dsp_rst(drst[0]), .busy(busy[0]), .done(done[0]), .csum(csum[0]));

  jtdsp16_prog_loader #(.AW(AW), .DW(DW), .RW(RW), .LEN(4), .BASE('h1000), .HOLD(0), .AUTO(0)) u1 (
    .clk(clk), .rst(rst[1]), .cen(cen[1]), .start(start[1]), .rom_cs(cs[1]), .rom_addr(raddr[1]),
    .rom_data(rdata[1]), .rom_ok(ok[1]), .prog_addr(paddr[1]), .prog_data(pdata[1]), .prog_we(we[1]),
    .dsp_rst(drst[1]), .busy(busy[1]), .done(done[1]), .csum(csum[1]));

  jtdsp16_prog_loader #(.AW(AW), .DW(DW), .RW(RW), .LEN(4096), .BASE(0), .HOLD(1), .AUTO(1)) u2 (
    .clk(clk), .rst(rst[2]), .cen(cen[2]), .start(start[2]), .rom_cs(cs[2]), .rom_addr(raddr[2]),
    .rom_data(rdata[2]), .rom_ok(ok[2]), .prog_addr(paddr[2]), .prog_data(pdata[2]), .prog_we(we[2]),
    .dsp_rst(drst[2]), .busy(busy[2]), .done(done[2]), .csum(csum[2]));

  function automatic int len_of(int k);
    case (k) 0: return 512; 1: return 4; default: return 4096; endcase
  endfunction
  function automatic int base_of(int k);
    return (k == 1) ? 'h1000 : 0;
  endfunction

  // ROM contents: word address xor a per-run seed (seed 0 gives rom[i]=i)
  function automatic logic [DW-1:0] rom_word(logic [RW-1:0] a, logic [DW-1:0] s);
    return a[DW-1:0] ^ s;
  endfunction

  function automatic logic [DW-1:0] model_csum(int k, logic [DW-1:0] s);
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < len_of(k); i++) acc += rom_word(RW'(base_of(k) + i), s);
    return acc;
  endfunction

  logic [DW-1:0] seed [3];
  int  lat_cfg [3];
  bit  noise   [3];
  int  rcnt [3];
  int  rlat [3];
  logic jbit [3];
  logic [DW-1:0] jdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_rom
    assign ok[g]    = cs[g] ? (rcnt[g] >= rlat[g]) : (noise[g] & jbit[g]);
    assign rdata[g] = (cs[g] && ok[g]) ? rom_word(raddr[g], seed[g]) : jdata[g];
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      jbit[k]  <= 1'($urandom_range(0, 1));
      jdata[k] <= DW'($urandom);
    end
  end

  int wcnt [3], werr [3], acnt [3], aerr [3], reqc [3], rerr [3];
  logic [AW-1:0] last_addr [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k] || !cs[k]) begin
        rcnt[k] <= 0;
        rlat[k] <= (lat_cfg[k] < 0) ? int'($urandom_range(0, 4)) : lat_cfg[k];
      end else if (cen[k] && !ok[k]) begin
        rcnt[k] <= rcnt[k] + 1;
      end
      if (rst[k] || clr[k]) begin
        wcnt[k] <= 0; werr[k] <= 0; acnt[k] <= 0; aerr[k] <= 0; reqc[k] <= 0;
        last_addr[k] <= '0;
      end else if (cen[k]) begin
        if (cs[k]) reqc[k] <= reqc[k] + 1;
        if (cs[k] && ok[k]) begin
          if (raddr[k] !== RW'(base_of(k) + acnt[k])) aerr[k] <= aerr[k] + 1;
          acnt[k] <= acnt[k] + 1;
        end
        if (we[k]) begin
          if (paddr[k] !== AW'(wcnt[k]) ||
              pdata[k] !== rom_word(RW'(base_of(k) + wcnt[k]), seed[k]))
            werr[k] <= werr[k] + 1;
          last_addr[k] <= paddr[k];
          wcnt[k] <= wcnt[k] + 1;
        end
      end
      if (!rst[k] && drst[k] == 1'b0 && done[k] == 1'b0) rerr[k] <= rerr[k] + 1;
    end
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(int k, int pat, bit start_busy, int budget, output int n, output bit fin);
    n = 0;
    fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      case (pat)
        0:       cen[k] = 1'b1;
        1:       cen[k] = ~cen[k];
        default: cen[k] = ($urandom_range(0, 9) < 7);
      endcase
      if (start_busy) start[k] = busy[k];
      @(posedge clk);
      if (cen[k]) n++;
      #1;
      if (done[k]) begin
        fin = 1'b1;
        break;
      end
    end
    start[k] = 1'b0;
  endtask

  task automatic idle(int k, int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      cen[k] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(int k);
    @(negedge clk);
    rst[k] = 1'b1;
    cen[k] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset(int k);
    @(negedge clk);
    rst[k] = 1'b0;
    cen[k] = 1'b0;
  endtask

  typedef struct {
    int            lat;
    int            pat;
    logic [DW-1:0] seed;
    logic [DW-1:0] exp_csum;
    int            exp_n;
    int            exp_req;
  } vec_t;

  vec_t vt [5];
  int   n;
  bit   fin;
  bit   hit;

  initial begin
    rst = '1; cen = '0; start = '0; clr = '0;
    for (int k = 0; k < 3; k++) begin
      seed[k] = '0; lat_cfg[k] = 0; noise[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs/we/busy/done", {cs[0], we[0], busy[0], done[0]}, 4'b0000);
    chk("reset dsp_rst", drst[0], 1'b1);
    chk("reset addr/data/csum", {raddr[0], paddr[0], pdata[0], csum[0]}, '0);

    vt[0] = '{0, 0, 16'h0000, 16'hFF00, 1029, 512};
    vt[1] = '{3, 0, 16'h1234, 16'h0000, 2565, 2048};
    vt[2] = '{0, 1, 16'h0000, 16'hFF00, 1029, 512};
    vt[3] = '{1, 2, 16'hFFFF, 16'h0000, 1541, 1024};
    vt[4] = '{-1, 2, DW'($urandom), 16'h0000, -1, -1};
    for (int v = 1; v < 5; v++) vt[v].exp_csum = model_csum(0, vt[v].seed);

    for (int v = 0; v < 5; v++) begin
      hold_reset(0);
      seed[0] = vt[v].seed;
      lat_cfg[0] = vt[v].lat;
      noise[0] = (vt[v].pat == 2);
      release_reset(0);
      run(0, vt[v].pat, 1'b0, 20000, n, fin);
      chk($sformatf("v%0d done reached", v), fin, 1'b1);
      if (vt[v].exp_n >= 0) chk($sformatf("v%0d cen cycles to done", v), n, vt[v].exp_n);
      if (vt[v].exp_req >= 0) chk($sformatf("v%0d REQ cycles", v), reqc[0], vt[v].exp_req);
      chk($sformatf("v%0d write count", v), wcnt[0], 512);
      chk($sformatf("v%0d write addr/data errors", v), werr[0], 0);
      chk($sformatf("v%0d rom accepts", v), acnt[0], 512);
      chk($sformatf("v%0d rom_addr errors", v), aerr[0], 0);
      chk($sformatf("v%0d csum", v), csum[0], vt[v].exp_csum);
      chk($sformatf("v%0d dsp_rst/busy", v), {drst[0], busy[0]}, 2'b00);
      idle(0, 6);
      chk($sformatf("v%0d no writes after done", v), wcnt[0], 512);
    end

    // reset in the middle of a load, with idx at 100
    hold_reset(0);
    seed[0] = '0; lat_cfg[0] = 0; noise[0] = 1'b0;
    release_reset(0);
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      cen[0] = 1'b1;
      @(posedge clk);
      #1;
      if (wcnt[0] == 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached idx 100", hit, 1'b1);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("midload rst we/cs/done/busy", {we[0], cs[0], done[0], busy[0]}, 4'b0000);
    chk("midload rst dsp_rst", drst[0], 1'b1);
    chk("midload rst csum", csum[0], 16'h0000);
    release_reset(0);
    run(0, 0, 1'b0, 20000, n, fin);
    chk("reload after rst done", fin, 1'b1);
    chk("reload after rst writes", wcnt[0], 512);
    chk("reload after rst order", werr[0], 0);
    chk("reload after rst csum", csum[0], 16'hFF00);
    @(negedge clk);
    rst[0] = 1'b1;

    // start-driven instance: no autostart, base offset, busy start ignored, reload
    hold_reset(1);
    release_reset(1);
    idle(1, 10);
    chk("u1 stays idle busy/cs/done", {busy[1], cs[1], done[1]}, 3'b000);
    chk("u1 idle dsp_rst", drst[1], 1'b1);
    chk("u1 idle no writes", wcnt[1], 0);
    @(negedge clk);
    start[1] = 1'b1;
    cen[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    chk("u1 start -> busy", busy[1], 1'b1);
    run(1, 0, 1'b1, 200, n, fin);
    chk("u1 done reached", fin, 1'b1);
    chk("u1 cen cycles to done", n + 1, 10);
    chk("u1 write count", wcnt[1], 4);
    chk("u1 write order", werr[1], 0);
    chk("u1 rom_addr sequence", aerr[1], 0);
    chk("u1 final rom_addr", raddr[1], 22'h1003);
    chk("u1 csum", csum[1], model_csum(1, 16'h0000));
    idle(1, 5);
    chk("u1 done holds", {done[1], busy[1], drst[1]}, 3'b100);
    chk("u1 no extra writes", wcnt[1], 4);

    seed[1] = 16'hA5C3;
    lat_cfg[1] = -1;
    noise[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b1;
    clr[1] = 1'b1;
    cen[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    clr[1] = 1'b0;
    chk("u1 restart busy/done/dsp_rst", {busy[1], done[1], drst[1]}, 3'b101);
    chk("u1 restart csum cleared", csum[1], 16'h0000);
    run(1, 2, 1'b1, 500, n, fin);
    chk("u1 reload done", fin, 1'b1);
    chk("u1 reload writes", wcnt[1], 4);
    chk("u1 reload order", werr[1], 0);
    chk("u1 reload rom_addr", aerr[1], 0);
    chk("u1 reload csum", csum[1], model_csum(1, 16'hA5C3));
    @(negedge clk);
    rst[1] = 1'b1;

    // full 2**AW image
    hold_reset(2);
    release_reset(2);
    run(2, 0, 1'b0, 20000, n, fin);
    chk("u2 done reached", fin, 1'b1);
    chk("u2 cen cycles to done", n, 2 * 4096 + 1 + 1);
    chk("u2 write count", wcnt[2], 4096);
    chk("u2 write order", werr[2], 0);
    chk("u2 last prog_addr", last_addr[2], 12'hFFF);
    chk("u2 csum", csum[2], model_csum(2, 16'h0000));
    idle(2, 20);
    chk("u2 no write after wrap", wcnt[2], 4096);
    chk("u2 done holds", done[2], 1'b1);

    chk("dsp_rst released only when done", rerr[0] + rerr[1] + rerr[2], 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
